// File: rtl/grid_frame_scanner_pkg.sv
// Shared types for the grid frame scanner: object codes and scan FSM states.
package grid_pkg;

  // Bit index in obj_req is code-1, so HEAD wins the priority encode.
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    BORDER = 3'd1,
    APPLE  = 3'd2,
    BODY   = 3'd3,
    HEAD   = 3'd4
  } obj_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT_CMD,
    FRAME_END
  } scan_state_t;

endpackage

// File: rtl/grid_frame_scanner_if.sv
// Scanner <-> game-state / command-engine signal bundle.
// GRID_DIFF_COUNT_EN adds the per-frame diff_count output.
interface grid_frame_scanner_if #(
  parameter int unsigned GRID_W  = 16,
  parameter int unsigned GRID_H  = 12,
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned X_W     = $clog2(GRID_W),
  parameter int unsigned Y_W     = $clog2(GRID_H),
  parameter int unsigned CODE_W  = $clog2(NUM_OBJ + 1)
);
`ifdef GRID_DIFF_COUNT_EN
  localparam int unsigned DC_W = $clog2(GRID_W * GRID_H + 1);
  logic [DC_W-1:0]   diff_count;
`endif
  logic [NUM_OBJ-1:0] obj_req;
  logic               frame_start;
  logic               full_redraw;
  logic               clear_map;
  logic               cmd_done;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [CODE_W-1:0]  obj_code;
  logic               diff;
  logic               init_cycle;
  logic               busy;
  logic               frame_done;

  modport master (
    input  obj_req, frame_start, full_redraw, clear_map, cmd_done,
`ifdef GRID_DIFF_COUNT_EN
    output diff_count,
`endif
    output x, y, obj_code, diff, init_cycle, busy, frame_done
  );

  modport slave (
    output obj_req, frame_start, full_redraw, clear_map, cmd_done,
`ifdef GRID_DIFF_COUNT_EN
    input  diff_count,
`endif
    input  x, y, obj_code, diff, init_cycle, busy, frame_done
  );

endinterface

// File: rtl/grid_frame_scanner_map_ram.sv
// Previous-frame object map: async read, sync write, address y*GRID_W+x.
module grid_map_ram #(
  parameter int unsigned GRID_W = 16,
  parameter int unsigned GRID_H = 12,
  parameter int unsigned CODE_W = 3,
  parameter int unsigned X_W    = $clog2(GRID_W),
  parameter int unsigned Y_W    = $clog2(GRID_H)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              we,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [CODE_W-1:0] wdata,
  output logic [CODE_W-1:0] rdata
);
  localparam int unsigned DEPTH = GRID_W * GRID_H;
  localparam int unsigned A_W   = $clog2(DEPTH);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [A_W-1:0]    addr_c;

  assign addr_c = A_W'(y) * A_W'(GRID_W) + A_W'(x);
  assign rdata  = mem[addr_c];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr_c] <= wdata;
    end
  end

endmodule

// File: rtl/grid_frame_scanner.sv
// Raster-scans the tile grid and requests a draw for each changed cell.
// GRID_DIFF_COUNT_EN adds a per-frame count of issued diffs.
module grid_frame_scanner
  import grid_pkg::*;
#(
  parameter int unsigned GRID_W  = 16,
  parameter int unsigned GRID_H  = 12,
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned X_W     = $clog2(GRID_W),
  parameter int unsigned Y_W     = $clog2(GRID_H),
  parameter int unsigned CODE_W  = $clog2(NUM_OBJ + 1)
) (
  input  logic                 clk,
  input  logic                 nrst,
  grid_frame_scanner_if.master bus
);
  scan_state_t       state;
  logic              redraw_all;
  logic [CODE_W-1:0] code_c;
  logic [CODE_W-1:0] map_rd_c;
  logic              need_draw_c;
  logic              map_we_c;
  logic              x_end_c;
  logic              last_cell_c;
  logic              advance_c;
  logic [X_W-1:0]    next_x_c;
  logic [Y_W-1:0]    next_y_c;

  // Priority encode: the highest set request bit overrides lower ones.
  always_comb begin
    code_c = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      if (bus.obj_req[i]) code_c = CODE_W'(i + 1);
    end
  end

  always_comb begin
    need_draw_c = (code_c != map_rd_c) || redraw_all;
    map_we_c    = (state == SCAN) && need_draw_c && !bus.clear_map;
    x_end_c     = (bus.x == X_W'(GRID_W - 1));
    last_cell_c = x_end_c && (bus.y == Y_W'(GRID_H - 1));
    advance_c   = ((state == SCAN) && !need_draw_c) ||
                  ((state == WAIT_CMD) && bus.cmd_done);
    next_x_c    = x_end_c ? '0 : bus.x + X_W'(1);
    next_y_c    = x_end_c ? bus.y + Y_W'(1) : bus.y;
  end

  grid_map_ram #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .CODE_W (CODE_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_map (
    .clk   (clk),
    .nrst  (nrst),
    .we    (map_we_c),
    .x     (bus.x),
    .y     (bus.y),
    .wdata (code_c),
    .rdata (map_rd_c)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      redraw_all     <= 1'b0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.obj_code   <= '0;
      bus.diff       <= 1'b0;
      bus.init_cycle <= 1'b1;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
`ifdef GRID_DIFF_COUNT_EN
      bus.diff_count <= '0;
`endif
    end else if (bus.clear_map) begin
      // Abort: the forced init frame repaints every cell, so the map is left as is.
      state          <= IDLE;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.diff       <= 1'b0;
      bus.init_cycle <= 1'b1;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.frame_done <= 1'b0;
          bus.x          <= '0;
          bus.y          <= '0;
          if (bus.frame_start) begin
            state      <= SCAN;
            bus.busy   <= 1'b1;
            redraw_all <= bus.init_cycle | bus.full_redraw;
`ifdef GRID_DIFF_COUNT_EN
            bus.diff_count <= '0;
`endif
          end
        end
        SCAN: begin
          if (need_draw_c) begin
            state        <= WAIT_CMD;
            bus.obj_code <= code_c;
            bus.diff     <= 1'b1;
`ifdef GRID_DIFF_COUNT_EN
            bus.diff_count <= bus.diff_count + 1'b1;
`endif
          end
        end
        WAIT_CMD: begin
          if (bus.cmd_done) bus.diff <= 1'b0;
        end
        FRAME_END: begin
          state          <= IDLE;
          bus.frame_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Step to the next cell; the final cell closes the frame.
      if (advance_c) begin
        if (last_cell_c) begin
          state          <= FRAME_END;
          bus.frame_done <= 1'b1;
          bus.init_cycle <= 1'b0;
          bus.busy       <= 1'b0;
          bus.x          <= '0;
          bus.y          <= '0;
        end else begin
          state <= SCAN;
          bus.x <= next_x_c;
          bus.y <= next_y_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_frame_scanner.sv
// Scoreboard bench for grid_frame_scanner (16x12 grid, 4 object lines).
module tb_grid_frame_scanner;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] code;
  } cell_t;

  logic tb_clk = 1'b0;
  logic nrst   = 1'b0;

  grid_frame_scanner_if bus ();

  grid_frame_scanner dut (
    .clk  (tb_clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial forever #5 tb_clk = ~tb_clk;

  int total = 0;
  int bad   = 0;
  int diffs_seen = 0;
  int fd_count   = 0;
  bit abort_armed = 1'b0;
  cell_t exp_q [$];
  logic [2:0] exp_map [12][16];

  int head_x = 4, head_y = 4;
  int apple_x = 7, apple_y = 4;

  // Game-state stand-in: object flags driven from the current cell.
  always_comb begin
    bus.obj_req = '0;
    if (bus.x == 4'd0 || bus.x == 4'd15 || bus.y == 4'd0 || bus.y == 4'd11) bus.obj_req[0] = 1'b1;
    if (32'(bus.x) == apple_x && 32'(bus.y) == apple_y) bus.obj_req[1] = 1'b1;
    if (32'(bus.x) == head_x && 32'(bus.y) == head_y) bus.obj_req[3] = 1'b1;
  end

  function automatic logic [2:0] scene_code(input int cx, input int cy);
    if (cx == head_x && cy == head_y) return 3'd4;
    if (cx == apple_x && cy == apple_y) return 3'd2;
    if (cx == 0 || cx == 15 || cy == 0 || cy == 11) return 3'd1;
    return 3'd0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_cell(input int cx, input int cy, input logic [2:0] c);
    cell_t e;
    e.x = 4'(cx);
    e.y = 4'(cy);
    e.code = c;
    exp_q.push_back(e);
  endtask

  // Reference model: queue the expected diffs for a frame, limited to the first 'cells'.
  task automatic push_frame(input bit redraw, input int cells);
    logic [2:0] c;
    for (int yy = 0; yy < 12; yy++) begin
      for (int xx = 0; xx < 16; xx++) begin
        if (yy * 16 + xx < cells) begin
          c = scene_code(xx, yy);
          if (redraw || c != exp_map[yy][xx]) push_cell(xx, yy, c);
          exp_map[yy][xx] = c;
        end
      end
    end
  endtask

  // Monitor: each rising diff is compared against the head of the queue.
  initial begin
    logic diff_q;
    cell_t got;
    diff_q = 1'b0;
    forever begin
      @(posedge tb_clk);
      #1;
      if (bus.frame_done) fd_count++;
      if (bus.diff && !diff_q) begin
        diffs_seen++;
        got = '{x: bus.x, y: bus.y, code: bus.obj_code};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_diff: got x=%0d y=%0d code=%0d expected none", got.x, got.y, got.code);
        end else begin
          cell_t e;
          e = exp_q.pop_front();
          if (got != e) begin
            bad++;
            $display("FAIL diff_cell: got x=%0d y=%0d code=%0d expected x=%0d y=%0d code=%0d",
                     got.x, got.y, got.code, e.x, e.y, e.code);
          end
        end
      end
      diff_q = bus.diff;
    end
  end

  // Command engine stand-in: acknowledge each draw request five cycles later.
  initial begin
    forever begin
      @(posedge tb_clk);
      #1;
      if (bus.diff && !(abort_armed && bus.x == 4'd3 && bus.y == 4'd2)) begin
        repeat (4) @(posedge tb_clk);
        #1 bus.cmd_done = 1'b1;
        @(posedge tb_clk);
        #1 bus.cmd_done = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge tb_clk);
    #1 bus.frame_start = 1'b1;
    @(posedge tb_clk);
    #1 bus.frame_start = 1'b0;
  endtask

  // Cycles counted from the edge that samples frame_start through the frame_done cycle.
  task automatic run_frame(input int budget, output int cycles);
    pulse_start();
    cycles = 1;
    while (!bus.frame_done && cycles < budget) begin
      @(posedge tb_clk);
      #1;
      cycles++;
    end
    if (!bus.frame_done) begin
      total++;
      bad++;
      $display("FAIL frame_done_timeout: got none expected pulse within %0d cycles", budget);
    end
  endtask

  initial begin
    int cyc;
    int fd_before;
    int waited;
    bus.frame_start = 1'b0;
    bus.full_redraw = 1'b0;
    bus.clear_map   = 1'b0;
    bus.cmd_done    = 1'b0;
    for (int yy = 0; yy < 12; yy++)
      for (int xx = 0; xx < 16; xx++) exp_map[yy][xx] = 3'd0;

    repeat (2) @(posedge tb_clk);
    #1;
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_diff", int'(bus.diff), 0);
    check("rst_init_cycle", int'(bus.init_cycle), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    nrst = 1'b1;

    // Init frame: every cell is repainted.
    push_frame(1'b1, 192);
    diffs_seen = 0;
    run_frame(4000, cyc);
    check("init_diffs", diffs_seen, 192);
    check("init_queue_left", exp_q.size(), 0);
    check("init_cycle_cleared", int'(bus.init_cycle), 0);
    check("busy_after_frame", int'(bus.busy), 0);

    // Unchanged scene: no draws, 192 scan cycles plus FRAME_END.
    push_frame(1'b0, 192);
    diffs_seen = 0;
    run_frame(1000, cyc);
    check("static_diffs", diffs_seen, 0);
    check("static_frame_cycles", cyc, 193);

    // Head moves one column right.
    head_x = 5;
    push_cell(4, 4, 3'd0);
    push_cell(5, 4, 3'd4);
    exp_map[4][4] = 3'd0;
    exp_map[4][5] = 3'd4;
    diffs_seen = 0;
    run_frame(1000, cyc);
    check("move_diffs", diffs_seen, 2);
    check("move_queue_left", exp_q.size(), 0);
`ifdef GRID_DIFF_COUNT_EN
    check("move_diff_count", int'(bus.diff_count), 2);
`endif

    // Force an init frame, then abort it while waiting on cell (3,2).
    @(posedge tb_clk);
    #1 bus.clear_map = 1'b1;
    @(posedge tb_clk);
    #1 bus.clear_map = 1'b0;
    check("clear_sets_init", int'(bus.init_cycle), 1);

    head_x = 0;
    head_y = 0;
    abort_armed = 1'b1;
    push_frame(1'b1, 36);
    diffs_seen = 0;
    fd_before = fd_count;
    pulse_start();
    waited = 0;
    while (!(bus.diff && bus.x == 4'd3 && bus.y == 4'd2) && waited < 2000) begin
      @(posedge tb_clk);
      #1;
      waited++;
    end
    check("reached_cell_3_2", int'(bus.diff && bus.x == 4'd3 && bus.y == 4'd2), 1);
    #1 bus.clear_map = 1'b1;
    @(posedge tb_clk);
    #1 bus.clear_map = 1'b0;
    abort_armed = 1'b0;
    check("abort_diff", int'(bus.diff), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_x", int'(bus.x), 0);
    check("abort_y", int'(bus.y), 0);
    check("abort_init_cycle", int'(bus.init_cycle), 1);
    repeat (10) @(posedge tb_clk);
    #1;
    check("abort_no_frame_done", fd_count, fd_before);
    check("abort_diffs", diffs_seen, 36);
    check("abort_queue_left", exp_q.size(), 0);

    // Following frame repaints everything again.
    push_frame(1'b1, 192);
    diffs_seen = 0;
    run_frame(4000, cyc);
    check("reinit_diffs", diffs_seen, 192);
    check("reinit_queue_left", exp_q.size(), 0);
`ifdef GRID_DIFF_COUNT_EN
    check("reinit_diff_count", int'(bus.diff_count), 192);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
